round_norm_pipe: RTL and testbench

ROUND_NORM_PIPE -- requirements
Module: round_norm_pipe

---
 rtl/round_norm_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_round_norm_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_norm_pipe.sv
// round_norm_pipe
//   Two-stage normalise-and-round back end for a floating-point multiplier.
//   Stage 1 normalises the raw mantissa product so its leading one sits in the
//   top bit and adjusts the exponent to match. Stage 2 rounds the product to
//   MAN_W bits in the requested mode and flags overflow and inexact results.
//   Each stage holds one beat and advances under a valid/ready handshake, so a
//   stalled output never loses, duplicates or reorders beats.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   in_valid     in   input beat present
//   in_ready     out  input beat accepted when in_valid && in_ready
//   in_man       in   IN_W-bit unsigned mantissa product in [1,4) or zero
//   in_exp       in   EXP_W-bit biased exponent before normalisation
//   in_sign      in   result sign
//   round_mode   in   000 to-zero, 001 +inf, 010 -inf, 011 nearest-even,
//                     100 nearest-ties-away, others as 000
//   out_valid    out  result beat present
//   out_ready    in   downstream takes the result beat
//   out_man      out  MAN_W-bit rounded mantissa (hidden bit included)
//   out_exp      out  EXP_W-bit result exponent
//   out_sign     out  result sign
//   out_inexact  out  rounding discarded non-zero bits
//   out_overflow out  exponent reached the all-ones encoding
module round_norm_pipe #(
    parameter int MAN_W = 24,
    parameter int IN_W  = 2 * MAN_W,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_man,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sign,
    input  logic [2:0]       round_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sign,
    output logic             out_inexact,
    output logic             out_overflow
);

    // Smallest exponent that no longer encodes a finite number.
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef struct packed {
        logic [MAN_W-1:0] man;
        logic [EXP_W-1:0] exp;
        logic             inexact;
        logic             overflow;
    } rnd_t;

    // Round a normalised product (leading one in the top bit) to MAN_W bits.
    // The exponent is carried one bit wider so a rounding carry out of an
    // already-large exponent is still seen as overflow rather than wrapping.
    function automatic rnd_t round_beat(
        input logic [IN_W-1:0] man,
        input logic [EXP_W:0]  exp,
        input logic            sign,
        input logic [2:0]      mode,
        input logic            zero
    );
        logic [MAN_W-1:0] kept;
        logic             guard;
        logic             sticky;
        logic             inexact;
        logic             inc;
        logic [MAN_W:0]   sum;
        logic [EXP_W:0]   exp_r;
        rnd_t             r;

        kept    = man[IN_W-1 -: MAN_W];
        guard   = man[IN_W-1-MAN_W];
        sticky  = |man[IN_W-2-MAN_W:0];
        inexact = guard | sticky;

        case (mode)
            3'b001:  inc = inexact & ~sign;
            3'b010:  inc = inexact & sign;
            3'b011:  inc = guard & (sticky | kept[0]);
            3'b100:  inc = guard;
            default: inc = 1'b0;
        endcase

        sum   = {1'b0, kept} + {{MAN_W{1'b0}}, inc};
        // A carry out means kept was all ones: the mantissa becomes 1.000...
        // and the exponent steps up once more.
        exp_r = exp + {{EXP_W{1'b0}}, sum[MAN_W]};

        r.man      = sum[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}} : sum[MAN_W-1:0];
        r.exp      = exp_r[EXP_W-1:0];
        r.inexact  = inexact;
        r.overflow = 1'b0;

        if (exp_r >= EXP_MAX) begin
            r.man      = '0;
            r.exp      = {EXP_W{1'b1}};
            r.inexact  = 1'b1;
            r.overflow = 1'b1;
        end

        // A zero product is exact regardless of the exponent it arrived with.
        if (zero) begin
            r = '0;
        end
        return r;
    endfunction

    logic             r_live;
    logic             r_vld_p1;
    logic [IN_W-1:0]  r_man_p1;
    logic [EXP_W:0]   r_exp_p1;
    logic             r_sign_p1;
    logic [2:0]       r_mode_p1;
    logic             r_zero_p1;

    logic             r_vld_p2;
    logic [MAN_W-1:0] r_man_p2;
    logic [EXP_W-1:0] r_exp_p2;
    logic             r_sign_p2;
    logic             r_inexact_p2;
    logic             r_overflow_p2;

    logic             w_load_p2;
    logic             w_accept;
    logic [IN_W-1:0]  w_man_norm;
    logic [EXP_W:0]   w_exp_norm;
    rnd_t             w_rnd;

    // Output stage can take a new beat when empty or when its beat leaves.
    assign w_load_p2 = ~r_vld_p2 | out_ready;
    // r_live keeps in_ready low during reset and for the first edge after it.
    assign in_ready  = r_live & (~r_vld_p1 | w_load_p2);
    assign w_accept  = in_valid & in_ready;

    assign w_man_norm = in_man[IN_W-1] ? in_man : {in_man[IN_W-2:0], 1'b0};
    assign w_exp_norm = {1'b0, in_exp} + {{EXP_W{1'b0}}, in_man[IN_W-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // ---- stage 1: normalise ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p1 <= 1'b0;
        end else if (in_ready) begin
            r_vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_man_p1  <= w_man_norm;
            r_exp_p1  <= w_exp_norm;
            r_sign_p1 <= in_sign;
            r_mode_p1 <= round_mode;
            r_zero_p1 <= (in_man == '0);
        end
    end

    // ---- stage 2: round ----
    assign w_rnd = round_beat(r_man_p1, r_exp_p1, r_sign_p1, r_mode_p1, r_zero_p1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p2      <= 1'b0;
            r_man_p2      <= '0;
            r_exp_p2      <= '0;
            r_sign_p2     <= 1'b0;
            r_inexact_p2  <= 1'b0;
            r_overflow_p2 <= 1'b0;
        end else if (w_load_p2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_man_p2      <= w_rnd.man;
                r_exp_p2      <= w_rnd.exp;
                r_sign_p2     <= r_sign_p1;
                r_inexact_p2  <= w_rnd.inexact;
                r_overflow_p2 <= w_rnd.overflow;
            end
        end
    end

    assign out_valid    = r_vld_p2;
    assign out_man      = r_man_p2;
    assign out_exp      = r_exp_p2;
    assign out_sign     = r_sign_p2;
    assign out_inexact  = r_inexact_p2;
    assign out_overflow = r_overflow_p2;

endmodule

// File: tb/tb_round_norm_pipe.sv
// Scoreboard bench for round_norm_pipe (MAN_W=24, IN_W=48, EXP_W=8).
// The driver pushes each accepted beat's hand-computed result into a queue;
// an independent monitor pops and compares whenever a result is taken.
module tb_round_norm_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_man = '0;
    logic [7:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic [2:0]  round_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_man;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_inexact;
    logic        out_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    typedef struct packed {
        logic [23:0] man;
        logic [7:0]  exp;
        logic        sign;
        logic        inex;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [47:0] man;
        logic [7:0]  exp;
        logic        sign;
        logic [2:0]  mode;
        res_t        res;
    } vec_t;

    res_t sb[$];
    vec_t vecs[$];
    res_t mon_act;
    res_t mon_exp;

    round_norm_pipe #(.MAN_W(24), .IN_W(48), .EXP_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_man(in_man), .in_exp(in_exp), .in_sign(in_sign),
        .round_mode(round_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_man(out_man), .out_exp(out_exp), .out_sign(out_sign),
        .out_inexact(out_inexact), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] man, input logic [7:0] exp,
                                input logic sign, input logic [2:0] mode,
                                input logic [23:0] rm, input logic [7:0] re,
                                input logic ri, input logic ro);
        vec_t v;
        v.man = man; v.exp = exp; v.sign = sign; v.mode = mode;
        v.res.man = rm; v.res.exp = re; v.res.sign = sign;
        v.res.inex = ri; v.res.ovf = ro;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge
    // with in_valid still high so a following send forms a back-to-back beat.
    task automatic send(input vec_t v);
        bit done;
        done       = 1'b0;
        in_valid   = 1'b1;
        in_man     = v.man;
        in_exp     = v.exp;
        in_sign    = v.sign;
        round_mode = v.mode;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(v.res);
                n_acc++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected acceptance");
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge clk);
        check("drain_queue_empty", sb.size(), 0);
        #1;
    endtask

    // Monitor: a beat is taken at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            mon_act = {out_man, out_exp, out_sign, out_inexact, out_overflow};
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got %h expected none", mon_act);
            end else begin
                mon_exp = sb.pop_front();
                check("result_beat", mon_act, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t snap;
        int   base;

        //            in_man              exp    s  mode  out_man     exp    inx ovf
        vecs.push_back(mk(48'h800000_000000, 8'd127, 0, 3'd3, 24'h800000, 8'd128, 0, 0));
        vecs.push_back(mk(48'h800000_800000, 8'd127, 0, 3'd3, 24'h800000, 8'd128, 1, 0));
        vecs.push_back(mk(48'h800000_800000, 8'd127, 0, 3'd4, 24'h800001, 8'd128, 1, 0));
        vecs.push_back(mk(48'h800000_800000, 8'd127, 0, 3'd0, 24'h800000, 8'd128, 1, 0));
        vecs.push_back(mk(48'hFFFFFF_FFFFFF, 8'd127, 0, 3'd1, 24'h800000, 8'd129, 1, 0));
        vecs.push_back(mk(48'hFFFFFF_FFFFFF, 8'd127, 1, 3'd1, 24'hFFFFFF, 8'd128, 1, 0));
        vecs.push_back(mk(48'h800000_000000, 8'd254, 0, 3'd3, 24'h000000, 8'hFF,  1, 1));
        vecs.push_back(mk(48'h000000_000000, 8'd100, 1, 3'd3, 24'h000000, 8'd0,   0, 0));
        vecs.push_back(mk(48'h400000_000001, 8'd127, 1, 3'd2, 24'h800001, 8'd127, 1, 0));
        vecs.push_back(mk(48'h800001_800000, 8'd10,  0, 3'd3, 24'h800002, 8'd11,  1, 0));
        vecs.push_back(mk(48'h800001_800000, 8'd10,  0, 3'd5, 24'h800001, 8'd11,  1, 0));
        vecs.push_back(mk(48'h800000_7FFFFF, 8'd10,  0, 3'd4, 24'h800000, 8'd11,  1, 0));
        vecs.push_back(mk(48'hFFFFFF_FFFFFF, 8'd253, 0, 3'd4, 24'h000000, 8'hFF,  1, 1));
        vecs.push_back(mk(48'h800000_000000, 8'd253, 1, 3'd3, 24'h800000, 8'hFE,  0, 0));
        vecs.push_back(mk(48'h800000_000000, 8'd50,  0, 3'd1, 24'h800000, 8'd51,  0, 0));

        // Reset state
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_outputs", {out_man, out_exp, out_sign, out_inexact, out_overflow}, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        // Directed vectors, back-to-back
        foreach (vecs[i]) send(vecs[i]);
        in_valid = 1'b0;
        drain();

        // Stall: three beats offered with the output blocked
        @(posedge clk); #1;
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                send(vecs[1]);
                send(vecs[2]);
                send(vecs[4]);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(negedge clk);
                check("stall_in_ready", in_ready, 0);
                check("stall_accepted", n_acc - base, 2);
                check("stall_out_valid", out_valid, 1);
                snap = {out_man, out_exp, out_sign, out_inexact, out_overflow};
                check("stall_head_value", snap, vecs[1].res);
                repeat (3) @(negedge clk);
                check("stall_hold", {out_man, out_exp, out_sign, out_inexact, out_overflow}, snap);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_total_accepted", n_acc - base, 3);

        // Reset in the middle of a stream discards in-flight beats at once
        out_ready = 1'b0;
        send(vecs[5]);
        send(vecs[6]);
        in_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 0);
        check("midreset_outputs", {out_man, out_exp, out_overflow}, 0);
        sb.delete();
        @(posedge clk); #1 rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_in_ready_release", in_ready, 1);
        @(posedge clk); #1;
        send(vecs[9]);
        in_valid = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check("no_leftover_beats", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
